// File: rtl/sw_input_unit.sv
// Switch input receiver: two-flop synchroniser, whole-word debouncer, and an
// LSU register window with a STABLE word and a sticky write-1-to-clear FLAGS word.
module sw_input_unit #(
    parameter int          SW_WIDTH  = 32,
    parameter int          DB_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [SW_WIDTH-1:0] i_io_sw,
    input  logic [31:0]         i_lsu_addr,
    input  logic                i_lsu_rden,
    input  logic                i_lsu_wren,
    input  logic [31:0]         i_lsu_wdata,
    output logic [31:0]         o_ld_data,
    output logic [SW_WIDTH-1:0] o_sw_stable,
    output logic                o_change
);

    localparam int              CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [29:0]     STABLE_WA = BASE_ADDR[31:2];
    localparam logic [29:0]     FLAGS_WA  = BASE_ADDR[31:2] + 30'd1;

    logic [SW_WIDTH-1:0] sync1_r;
    logic [SW_WIDTH-1:0] sync2_r;
    logic [SW_WIDTH-1:0] cand_r;
    logic [SW_WIDTH-1:0] stable_r;
    logic [SW_WIDTH-1:0] flags_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [31:0]         ld_data_r;

    logic                sel_stable_s;
    logic                sel_flags_s;
    logic                commit_s;
    logic [SW_WIDTH-1:0] set_mask_s;
    logic [SW_WIDTH-1:0] clr_mask_s;
    logic [SW_WIDTH-1:0] flags_nxt_s;
    logic [31:0]         rd_value_s;
    logic                unused_bits_s;

    assign unused_bits_s = ^{i_lsu_addr[1:0], i_lsu_wdata};

    // Address decode, debounce commit detection, flag next-state and read mux.
    always_comb begin
        sel_stable_s = (i_lsu_addr[31:2] == STABLE_WA);
        sel_flags_s  = (i_lsu_addr[31:2] == FLAGS_WA);
        commit_s     = (sync2_r == cand_r) && (cnt_r == CNT_MAX) && (cand_r != stable_r);
        if (commit_s) begin
            set_mask_s = cand_r ^ stable_r;
        end else begin
            set_mask_s = {SW_WIDTH{1'b0}};
        end
        if (i_lsu_wren && sel_flags_s) begin
            clr_mask_s = i_lsu_wdata[SW_WIDTH-1:0];
        end else begin
            clr_mask_s = {SW_WIDTH{1'b0}};
        end
        // Set side is applied last so a same-cycle commit beats the clear.
        flags_nxt_s = (flags_r & ~clr_mask_s) | set_mask_s;
        rd_value_s  = 32'd0;
        if (sel_stable_s) begin
            rd_value_s[SW_WIDTH-1:0] = stable_r;
        end else if (sel_flags_s) begin
            rd_value_s[SW_WIDTH-1:0] = flags_r;
        end else begin
            rd_value_s = 32'd0;
        end
    end

    // Synchroniser, debounce candidate/counter and committed switch value.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_r  <= {SW_WIDTH{1'b0}};
            sync2_r  <= {SW_WIDTH{1'b0}};
            cand_r   <= {SW_WIDTH{1'b0}};
            stable_r <= {SW_WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= i_io_sw;
            sync2_r <= sync1_r;
            if (sync2_r != cand_r) begin
                cand_r <= sync2_r;
                cnt_r  <= {CNT_W{1'b0}};
            end else if (cnt_r < CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (commit_s) begin
                stable_r <= cand_r;
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    // Sticky change flags and registered LSU read data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            flags_r   <= {SW_WIDTH{1'b0}};
            ld_data_r <= 32'd0;
        end else begin
            flags_r <= flags_nxt_s;
            if (i_lsu_rden) begin
                ld_data_r <= rd_value_s;
            end else begin
                ld_data_r <= ld_data_r;
            end
        end
    end

    assign o_ld_data   = ld_data_r;
    assign o_sw_stable = stable_r;
    assign o_change    = |flags_r;

endmodule
